// File: rtl/dds_symbol_scheduler.sv
// Symbol-rate controller for the DDS sine datapath: gates DDS reset, counts
// samples per symbol and applies ASK or BPSK keying to the DDS output.
`timescale 1ns/1ps
module dds_symbol_scheduler #(
    parameter int unsigned SAMPLES_PER_PERIOD = 256,
    parameter int unsigned DDS_LAT            = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic [7:0] cfg_periods,
    input  logic       sym_valid,
    input  logic       sym_bit,
    output logic       sym_ready,
    output logic       dds_rst_n,
    input  logic [8:0] dds_sample,
    output logic [8:0] mod_out,
    output logic       mod_valid,
    output logic       sym_done,
    output logic       busy
);

    localparam int unsigned SW = $clog2(SAMPLES_PER_PERIOD);
    localparam int unsigned LW = (DDS_LAT > 1) ? $clog2(DDS_LAT) : 1;
    localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLES_PER_PERIOD - 1);
    localparam logic [SW-1:0] SAMP_PRE  = SW'(SAMPLES_PER_PERIOD - 2);
    localparam logic [LW-1:0] LAT_LAST  = LW'((DDS_LAT > 0) ? DDS_LAT - 1 : 0);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t        state;
    logic [SW-1:0] samp_cnt;
    logic [7:0]    per_cnt;
    logic [7:0]    periods;
    logic [LW-1:0] wait_cnt;
    logic          latched_bit;
    logic          latched_mode;

    logic          last_c;
    logic          pre_last_c;
    logic [8:0]    neg_c;
    logic [8:0]    key_c;

    // Last-sample detection, plus one cycle early so sym_ready can be registered
    always_comb begin
        last_c     = (state == RUN) && (samp_cnt == SAMP_LAST) && (per_cnt == periods - 8'd1);
        pre_last_c = (state == RUN) && (samp_cnt == SAMP_PRE) && (per_cnt == periods - 8'd1);
    end

    // Keying; -(-256) has no 9-bit representation so it clips to +255
    always_comb begin
        neg_c = (dds_sample == 9'h100) ? 9'h0FF : 9'(~dds_sample + 9'd1);
        key_c = 9'd0;
        if (latched_bit)
            key_c = dds_sample;
        else if (latched_mode)
            key_c = neg_c;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            samp_cnt     <= '0;
            per_cnt      <= 8'd0;
            periods      <= 8'd0;
            wait_cnt     <= '0;
            latched_bit  <= 1'b0;
            latched_mode <= 1'b0;
            sym_ready    <= 1'b1;
            dds_rst_n    <= 1'b0;
            mod_out      <= 9'd0;
            mod_valid    <= 1'b0;
            sym_done     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sym_done  <= last_c;
            mod_valid <= (state == RUN);
            mod_out   <= (state == RUN) ? key_c : 9'd0;
            case (state)
                IDLE: begin
                    if (sym_valid && sym_ready) begin
                        latched_bit  <= sym_bit;
                        latched_mode <= mode;
                        periods      <= (cfg_periods == 8'd0) ? 8'd1 : cfg_periods;
                        samp_cnt     <= '0;
                        per_cnt      <= 8'd0;
                        wait_cnt     <= '0;
                        sym_ready    <= 1'b0;
                        dds_rst_n    <= 1'b1;
                        busy         <= 1'b1;
                        state        <= (DDS_LAT == 0) ? RUN : PRIME;
                    end
                end
                PRIME: begin
                    if (wait_cnt == LAT_LAST)
                        state <= RUN;
                    else
                        wait_cnt <= wait_cnt + LW'(1);
                end
                RUN: begin
                    if (last_c) begin
                        // Back-to-back accept keeps the DDS running for phase continuity
                        if (sym_valid) begin
                            latched_bit  <= sym_bit;
                            latched_mode <= mode;
                            periods      <= (cfg_periods == 8'd0) ? 8'd1 : cfg_periods;
                            samp_cnt     <= '0;
                            per_cnt      <= 8'd0;
                            sym_ready    <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            sym_ready <= 1'b1;
                            dds_rst_n <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end else begin
                        samp_cnt  <= samp_cnt + SW'(1);
                        sym_ready <= pre_last_c;
                        if (samp_cnt == SAMP_LAST)
                            per_cnt <= per_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
